// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator display path.
//   state_e        : IDLE / SHIFT / DONE sequencing of the BCD converter
//   BCD_NIBBLE     : bits per BCD digit
//   BCD_ADJ_THRESH : nibble value at or above which shift-add-3 adds 3
//   max_decimal()  : largest value displayable with a given digit count
// -----------------------------------------------------------------------------
package calc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int BCD_NIBBLE     = 4;
   localparam int BCD_ADJ_THRESH = 5;

   // 10^digits - 1, evaluated at elaboration time for the overflow compare.
   function automatic int max_decimal(input int digits);
      int r;
      r = 1;
      for (int i = 0; i < digits; i++) begin
         r = r * 10;
      end
      return r - 1;
   endfunction

endpackage : calc_pkg

// File: rtl/bcd_convert_seq_if.sv
// -----------------------------------------------------------------------------
// bcd_convert_seq_if
// Request / result bundle between operation_ctrl (master) and the sequential
// binary-to-BCD converter (slave).
//   start    : conversion request (master -> slave)
//   bin_in   : unsigned binary magnitude, IN_W bits
//   neg_in   : sign of the result
//   busy     : conversion in progress
//   done     : one-cycle completion pulse
//   bcd_out  : packed BCD digits, digit 0 in bits [3:0]
//   neg_out  : captured sign, held with bcd_out
//   overflow : captured magnitude exceeded 10^DIGITS-1
// -----------------------------------------------------------------------------
interface bcd_convert_seq_if #(
   parameter int IN_W   = 14,
   parameter int DIGITS = 4
);
   import calc_pkg::*;

   logic                           start;
   logic [IN_W-1:0]                bin_in;
   logic                           neg_in;
   logic                           busy;
   logic                           done;
   logic [DIGITS*BCD_NIBBLE-1:0]   bcd_out;
   logic                           neg_out;
   logic                           overflow;

   modport master (
      output start, bin_in, neg_in,
      input  busy, done, bcd_out, neg_out, overflow
   );

   modport slave (
      input  start, bin_in, neg_in,
      output busy, done, bcd_out, neg_out, overflow
   );

endinterface : bcd_convert_seq_if

// File: rtl/bcd_convert_seq_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Combinational shift-add-3 nibble correction: a BCD digit that would reach
// 10 or more after the next left shift is pre-biased by +3 so the shift
// carries cleanly into the next digit.
//   nib_i : BCD nibble before correction
//   nib_o : corrected nibble (nib_i >= 5 ? nib_i + 3 : nib_i)
// -----------------------------------------------------------------------------
module bcd_add3
   import calc_pkg::*;
(
   input  logic [BCD_NIBBLE-1:0] nib_i,
   output logic [BCD_NIBBLE-1:0] nib_o
);

   assign nib_o = (nib_i >= BCD_NIBBLE'(BCD_ADJ_THRESH))
                ? nib_i + BCD_NIBBLE'(3)
                : nib_i;

endmodule : bcd_add3

// File: rtl/bcd_convert_seq.sv
// -----------------------------------------------------------------------------
// bcd_convert_seq
// Sequential binary-to-BCD converter (double dabble) feeding the per-digit
// seven-segment decoders. One conversion per accepted start; the result,
// sign and overflow flag are held stable between done pulses so the display
// never sees intermediate shift values.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : bcd_convert_seq_if.slave (start/bin_in/neg_in in,
//         busy/done/bcd_out/neg_out/overflow out)
// Latency: start accepted at edge N -> busy in cycles N+1..N+IN_W,
//          done in cycle N+IN_W+1.
// -----------------------------------------------------------------------------
module bcd_convert_seq
   import calc_pkg::*;
#(
   parameter int IN_W   = 14,
   parameter int DIGITS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   bcd_convert_seq_if.slave     bus
);

   localparam int BCD_W = DIGITS * BCD_NIBBLE;
   localparam int SR_W  = BCD_W + IN_W;
   localparam int CNT_W = $clog2(IN_W + 1);

   // Values above this are shown as all nines with the overflow flag set.
   localparam logic [IN_W-1:0]  MAX_DEC   = IN_W'(max_decimal(DIGITS));
   localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_e              state_q,   state_d;
   logic [SR_W-1:0]     sr_q,      sr_d;       // {BCD digits, binary remainder}
   logic [CNT_W-1:0]    cnt_q,     cnt_d;      // shifts still to perform
   logic                neg_cap_q, neg_cap_d;  // sign captured at acceptance
   logic                ovf_cap_q, ovf_cap_d;  // overflow captured at acceptance
   logic [BCD_W-1:0]    bcd_q,     bcd_d;      // displayed result
   logic                neg_q,     neg_d;
   logic                ovf_q,     ovf_d;

   // ---------------------------------------------------------------------------
   // Shift-add-3 datapath: correct every BCD nibble, then shift left by one.
   // ---------------------------------------------------------------------------
   logic [BCD_W-1:0]    adj_bcd;
   logic [SR_W-1:0]     sr_adj;
   logic [SR_W-1:0]     sr_shift;

   for (genvar d = 0; d < DIGITS; d++) begin : g_add3
      bcd_add3 u_add3 (
         .nib_i (sr_q[IN_W + d*BCD_NIBBLE +: BCD_NIBBLE]),
         .nib_o (adj_bcd[d*BCD_NIBBLE +: BCD_NIBBLE])
      );
   end

   assign sr_adj   = {adj_bcd, sr_q[IN_W-1:0]};
   // The bit shifted out of the top only matters for inputs above MAX_DEC,
   // and those are replaced by ALL_NINES anyway.
   assign sr_shift = sr_adj << 1;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every _d gets its hold value first so no path leaves a variable
      // unassigned, which would otherwise infer a latch.
      state_d   = state_q;
      sr_d      = sr_q;
      cnt_d     = cnt_q;
      neg_cap_d = neg_cap_q;
      ovf_cap_d = ovf_cap_q;
      bcd_d     = bcd_q;
      neg_d     = neg_q;
      ovf_d     = ovf_q;

      unique case (state_q)
         // IDLE and DONE accept a request identically; DONE accepting it gives
         // back-to-back conversions with no idle gap.
         IDLE, DONE: begin
            state_d = IDLE;
            if (bus.start) begin
               state_d   = SHIFT;
               sr_d      = {{BCD_W{1'b0}}, bus.bin_in};
               cnt_d     = CNT_W'(IN_W);
               neg_cap_d = bus.neg_in;
               ovf_cap_d = (bus.bin_in > MAX_DEC);
            end
         end

         SHIFT: begin
            sr_d  = sr_shift;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               // Final shift: publish the result so it is already valid in
               // the DONE cycle, where done is asserted.
               state_d = DONE;
               bcd_d   = ovf_cap_q ? ALL_NINES : sr_shift[SR_W-1 -: BCD_W];
               neg_d   = neg_cap_q;
               ovf_d   = ovf_cap_q;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         sr_q      <= '0;
         cnt_q     <= '0;
         neg_cap_q <= 1'b0;
         ovf_cap_q <= 1'b0;
         bcd_q     <= '0;
         neg_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // values from before this edge, independent of statement order.
         state_q   <= state_d;
         sr_q      <= sr_d;
         cnt_q     <= cnt_d;
         neg_cap_q <= neg_cap_d;
         ovf_cap_q <= ovf_cap_d;
         bcd_q     <= bcd_d;
         neg_q     <= neg_d;
         ovf_q     <= ovf_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.busy     = (state_q == SHIFT);
   assign bus.done     = (state_q == DONE);
   assign bus.bcd_out  = bcd_q;
   assign bus.neg_out  = neg_q;
   assign bus.overflow = ovf_q;

endmodule : bcd_convert_seq

// File: doc/bcd_convert_seq.md
Name: bcd_convert_seq

Overview:
- Sequential binary-to-BCD converter using shift-add-3 (double dabble).
- Sits between operation_ctrl and the per-digit seven-segment decoders.
- Replaces the combinational %/÷ digit extraction on the sum, difference, product and quotient results.
- Converts one binary result per start request, handshakes completion, and holds the packed BCD digits plus sign/overflow flags for the display path.

Parameters:
- IN_W, 14, width of the unsigned binary magnitude input.
- DIGITS, 4, number of BCD output digits; the displayable maximum is 10^DIGITS-1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset: low clears all state immediately; release is synchronous to clk.
- start  in  1  conversion request; sampled only in IDLE or DONE.
- bin_in  in  IN_W  unsigned magnitude; captured on the accepted start cycle.
- neg_in  in  1  sign of the result (negsign from operation_ctrl); captured with bin_in.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  single-cycle pulse; bcd_out, neg_out and overflow are valid from this cycle on.
- bcd_out  out  4*DIGITS  packed BCD, digit 0 in bits [3:0]; held until the next done.
- neg_out  out  1  captured sign; held with bcd_out.
- overflow  out  1  high when the captured bin_in exceeded 10^DIGITS-1; held with bcd_out.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; the shift register and bit counter clear.
  - busy=0, done=0, bcd_out=0, neg_out=0, overflow=0.
- States: IDLE, SHIFT, DONE (encoding taken from the shared package).
- IDLE:
  - When start=1, load the shift register with {DIGITS*4 zeros, bin_in}.
  - Capture neg_in and the overflow compare (bin_in > 10^DIGITS-1), set the counter to IN_W, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, each cycle:
  - Every BCD nibble >= 5 gets +3, then the whole register shifts left by 1 and the counter decrements.
  - When the counter reaches 1 on the current cycle, the final shift is performed and the state goes to DONE.
  - Exactly IN_W cycles are spent in SHIFT.
- DONE (one cycle):
  - done=1, busy=0.
  - bcd_out is updated from the register, or forced to all nines (0x9999 for DIGITS=4) when overflow is set; neg_out and overflow are updated.
  - If start=1 in this cycle, load as in IDLE and go to SHIFT (back-to-back allowed); otherwise go to IDLE.
- Latency: start accepted at edge N, so busy=1 in cycles N+1..N+IN_W and done=1 in cycle N+IN_W+1 (15 cycles for IN_W=14).
- start while busy: ignored, with no effect on the conversion in flight or on the outputs.
- bin_in and neg_in changing while busy: no effect; the values are captured only at acceptance.
- Outputs stay stable between done pulses; the displays never see intermediate shift values.
- rst low mid-conversion: the conversion is aborted, outputs clear to 0, and no done is issued.
- Widths:
  - Shift register is 4*DIGITS+IN_W bits.
  - Counter is clog2(IN_W+1) bits.
  - The overflow compare uses an IN_W-bit constant; DIGITS=4 gives 9999.

Decomposition:
- Shared package calc_pkg holds:
  - state enum {IDLE, SHIFT, DONE};
  - constants BCD_NIBBLE=4 and BCD_ADJ_THRESH=5;
  - function max_decimal(DIGITS) returning 10^DIGITS-1.
- One natural sub-module, bcd_add3: a combinational 4-bit nibble adjust (in >= 5 ? in+3 : in), instantiated DIGITS times in a generate loop.

Test Plan:
- Reset, then start with bin_in=0 -> done exactly 15 cycles after the accepting edge; bcd_out=0x0000, overflow=0, neg_out=0.
- bin_in=1234, neg_in=1 -> bcd_out=0x1234, neg_out=1, overflow=0; busy high for exactly 14 cycles.
- bin_in=9999 -> 0x9999, overflow=0. Then bin_in=10000 -> 0x9999, overflow=1. Then bin_in=16383 -> 0x9999, overflow=1.
- Start with bin_in=81, then pulse start with bin_in=500 at cycle 5 of busy -> single done, bcd_out=0x0081; no second done follows.
- Start held high continuously with bin_in=42, then 7 -> done pulses every 15 cycles; bcd_out=0x0042 at the first pulse and 0x0007 at the second.
- Start with bin_in=255, assert rst low at cycle 8 -> outputs immediately 0; done never pulses. After release, start with 255 -> 0x0255.
